// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmit path. Each byte is issued with a
// one-cycle start pulse, followed by a fixed frame gap before the next pulse.
module uart_tx_feeder #(
    parameter logic [31:0] CLOCK_FREQ      = 32'd50_000_000,
    parameter logic [31:0] UART_BAUD       = 32'd115200,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [31:0] FRAME_GAP_BITS  = 32'd11
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_DEPTH_LOG2:0]   level,
    output logic                       overflow,
    output logic                       busy,
    output logic [7:0]                 uart_tx_data,
    output logic                       uart_tx_enable
);
    localparam logic [31:0] BAUD_RATE_CNT = CLOCK_FREQ / UART_BAUD;
    localparam logic [31:0] GAP_CYCLES    = BAUD_RATE_CNT * FRAME_GAP_BITS;
    localparam int          DEPTH         = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] LVL_FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                     r_state;
    logic [31:0]                r_gap_cnt;
    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;

    logic                       w_push;
    logic                       w_pop;
    logic [FIFO_DEPTH_LOG2:0]   w_level_nxt;

    // Acceptance uses only registered flags, so a same-cycle pop never frees a slot early.
    assign w_push = wr_en && !full;
    assign w_pop  = (r_state == IDLE) && !empty;
    assign busy   = (r_state != IDLE) || !empty;

    always_comb begin
        w_level_nxt = level;
        if (w_push && !w_pop)
            w_level_nxt = level + 1'b1;
        else if (!w_push && w_pop)
            w_level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            level <= w_level_nxt;
            full  <= (w_level_nxt == LVL_FULL);
            empty <= (w_level_nxt == '0);
        end
    end

    // Reset lands in WAIT so a frame already on the line downstream can finish.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= WAIT;
            r_gap_cnt      <= GAP_CYCLES - 32'd1;
            uart_tx_data   <= 8'h00;
            uart_tx_enable <= 1'b0;
        end else begin
            uart_tx_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!empty) begin
                        uart_tx_data <= r_mem[r_rd_ptr];
                        r_state      <= START;
                    end
                end
                START: begin
                    uart_tx_enable <= 1'b1;
                    r_gap_cnt      <= GAP_CYCLES - 32'd1;
                    r_state        <= WAIT;
                end
                WAIT: begin
                    if (r_gap_cnt == 32'd0)
                        r_state <= IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt - 32'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte buffer and pacing controller that sits directly upstream of the UART transmit path. Producers push bytes into a small circular FIFO. The block pops one byte at a time and presents it on uart_tx_data with a one-cycle uart_tx_enable pulse. It then holds off the next byte for a fixed frame time, so the transmit path is never re-triggered mid-frame (that path has no busy output).

Parameters:
CLOCK_FREQ, 32'd50_000_000, system clock frequency in Hz
UART_BAUD, 32'd115200, line baud rate
FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 entries (default 16)
FRAME_GAP_BITS, 11, bit times reserved per frame (10 frame bits + 1 guard)
BAUD_RATE_CNT, CLOCK_FREQ/UART_BAUD, derived: clocks per bit
GAP_CYCLES, BAUD_RATE_CNT*FRAME_GAP_BITS, derived: WAIT duration in clocks

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
wr_data  input  8  byte to enqueue
wr_en  input  1  enqueue strobe, sampled each clk_in rising edge
full  output  1  FIFO holds 2**FIFO_DEPTH_LOG2 entries (registered)
empty  output  1  FIFO holds 0 entries (registered)
level  output  FIFO_DEPTH_LOG2+1  current entry count (registered)
overflow  output  1  one-cycle pulse: a write was dropped
busy  output  1  high when state != IDLE or !empty
uart_tx_data  output  8  byte to the transmit path; stable from START until next pop
uart_tx_enable  output  1  one-cycle start pulse to the transmit path

Behaviour:
- Reset, while rst_n low, immediate:
  - wr/rd pointers = 0, level = 0, full = 0, empty = 1, overflow = 0.
  - uart_tx_data = 8'h00, uart_tx_enable = 0.
  - state = WAIT, gap counter = GAP_CYCLES-1, busy = 1.
  - The post-reset guard lets any frame already in flight downstream finish before new data is issued.
- FIFO:
  - Circular buffer with pointers of FIFO_DEPTH_LOG2 bits; wrap from max to 0.
  - Write accepted iff wr_en && !full, using the registered full and independent of a same-cycle pop.
  - Rejected write (wr_en && full): data discarded, overflow = 1 on the next cycle only.
  - Pop occurs only in IDLE with registered empty = 0.
  - Simultaneous accepted write and pop: level unchanged, both pointers advance.
  - level, full and empty are all updated in the same cycle as the pointer change.
- FSM, 3 states:
  - IDLE: if !empty → pop head into uart_tx_data, go to START; else stay.
  - START: uart_tx_enable = 1 for exactly this cycle; load counter = GAP_CYCLES-1; go to WAIT.
  - WAIT: uart_tx_enable = 0; decrement counter; when counter == 0 → IDLE.
- Timing:
  - Write-to-enable latency from an idle, empty block: write sampled at edge N, enable high during cycle N+2.
  - Back-to-back bytes: consecutive enable pulses spaced exactly GAP_CYCLES+2 clocks apart.
  - uart_tx_data changes only on a pop.
- Arithmetic: gap counter is 32 bits and never underflows; level = writes - pops, range 0..2**FIFO_DEPTH_LOG2.
- Reset mid-operation: FIFO contents are lost and no stale byte is ever issued. The post-reset guard then applies, followed by IDLE.

Test Plan:
Sim parameters: CLOCK_FREQ=1_000_000, UART_BAUD=100_000 (BAUD_RATE_CNT=10, GAP_CYCLES=110), FIFO_DEPTH_LOG2=4.
1. Reset release, no writes → empty=1, level=0, busy=1 for 110 cycles then 0; uart_tx_enable never asserted.
2. After guard, write 8'hA5 at edge N → uart_tx_enable high only in cycle N+2, uart_tx_data=8'hA5 from N+2; busy returns low 110 cycles after the pulse.
3. Write 8'h11, 8'h22, 8'h33 on 3 consecutive cycles → three enable pulses 112 cycles apart carrying 8'h11, 8'h22, 8'h33 in order; level peaks at 2.
4. Write bytes 0..17 on 18 consecutive cycles from idle → full=1 after byte 16, byte 17 dropped, overflow high for exactly one cycle; bytes 0..16 transmitted in order, then empty=1.
5. With FIFO full, assert wr_en on the same cycle as an IDLE pop → write rejected, overflow pulses, level goes 16→15.
6. Assert rst_n low during WAIT with level=5 → outputs take reset values asynchronously (before the next edge); after release, 110-cycle guard, then no enable pulse without a new write.
